// File: rtl/right_shifter_seq_4b.sv
// Multi-cycle right shifter: 4-position steps while at least 4 remain, then 1-position steps.
// Optional sign fill is enabled by defining RSHIFT_ARITH_EN; otherwise the shift is logical.
module right_shifter_seq_4b #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   amt,
    input  logic             arith,
    output logic [WIDTH-1:0] out,
    output logic             sticky,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             fill;
    logic [WIDTH-1:0] step1, step4;

`ifdef RSHIFT_ARITH_EN
    logic fill_q, fill_d;
    assign fill = fill_q;
`else
    logic unused_arith;
    assign fill         = 1'b0;
    assign unused_arith = arith;
`endif

    // Candidate next values for one 1-position step and one 4-position step.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi < WIDTH - 1) begin : g_s1
                assign step1[gi] = out_q[gi+1];
            end else begin : g_s1f
                assign step1[gi] = fill;
            end
            if (gi < WIDTH - 4) begin : g_s4
                assign step4[gi] = out_q[gi+4];
            end else begin : g_s4f
                assign step4[gi] = fill;
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
`ifdef RSHIFT_ARITH_EN
        fill_d   = fill_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    out_d    = in;
                    cnt_d    = amt;
                    sticky_d = 1'b0;
`ifdef RSHIFT_ARITH_EN
                    fill_d   = arith & in[WIDTH-1];
`endif
                    state_d  = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q >= SHW'(4)) begin
                    out_d    = step4;
                    sticky_d = sticky_q | (|out_q[3:0]);
                    cnt_d    = cnt_q - SHW'(4);
                end else begin
                    out_d    = step1;
                    sticky_d = sticky_q | out_q[0];
                    cnt_d    = cnt_q - SHW'(1);
                end
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
`ifdef RSHIFT_ARITH_EN
            fill_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
`ifdef RSHIFT_ARITH_EN
            fill_q   <= fill_d;
`endif
        end
    end

    assign out    = out_q;
    assign sticky = sticky_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_right_shifter_seq_4b.sv
// Bench for right_shifter_seq_4b: directed cases with literal expectations plus randomized
// traffic checked every cycle against a result/latency model computed from shift arithmetic.
module tb_right_shifter_seq_4b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_in = '0;
    logic [3:0]  op_amt = '0;
    logic        op_arith = 1'b0;
    logic [15:0] dut_out;
    logic        sticky, busy, done;

    int errors = 0;
    int checks = 0;

    right_shifter_seq_4b #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(op_in), .amt(op_amt),
        .arith(op_arith), .out(dut_out), .sticky(sticky), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_out(input logic [15:0] v, input int a, input logic ar);
        logic        f;
        logic [31:0] ext;
`ifdef RSHIFT_ARITH_EN
        f = ar & v[15];
`else
        f = ar & 1'b0;
`endif
        ext = {{16{f}}, v};
        ext = ext >> a;
        return ext[15:0];
    endfunction

    function automatic logic ref_stk(input logic [15:0] v, input int a);
        logic [15:0] m;
        m = (16'h1 << a) - 16'h1;
        return |(v & m);
    endfunction

    function automatic int ref_steps(input int a);
        return a / 4 + a % 4;
    endfunction

    // Reference model: which cycle the result appears in and what it is.
    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    int          m_left = 0;
    logic [15:0] m_out = '0;
    logic        m_stk = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_left   = 0;
            m_out    = '0;
            m_stk    = 1'b0;
        end else if (m_valid) begin
            if (m_active) begin
                if (m_left == 0) m_active = 1'b0;
                else m_left--;
            end else if (start) begin
                m_active = 1'b1;
                m_left   = ref_steps(int'(op_amt));
                m_out    = ref_out(op_in, int'(op_amt), op_arith);
                m_stk    = ref_stk(op_in, int'(op_amt));
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model busy", int'(busy), int'(m_active));
            chk("model done", int'(done), int'(m_active && m_left == 0));
            if (!m_active || m_left == 0) begin
                chk("model out", int'(dut_out), int'(m_out));
                chk("model sticky", int'(sticky), int'(m_stk));
            end
        end
    end

    task automatic run_op(input string nm, input logic [15:0] v, input int a, input logic ar,
                          input logic [15:0] eo, input logic es, input int ek);
        int n;
        @(negedge clk);
        op_in = v; op_amt = a[3:0]; op_arith = ar; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, ek);
        chk({nm, " out"}, int'(dut_out), int'(eo));
        chk({nm, " sticky"}, int'(sticky), int'(es));
        $display("op %s: in=%h amt=%0d arith=%0d -> out=%h sticky=%0d after %0d steps",
                 nm, v, a, ar, dut_out, sticky, n);
        @(negedge clk);
        chk({nm, " busy low"}, int'(busy), 0);
    endtask

    initial begin
        int   pulses;
        logic [15:0] seen_out;
        logic        seen_stk;

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset out", int'(dut_out), 0);
        chk("reset sticky", int'(sticky), 0);
        rst_n = 1'b1;

        run_op("amt0", 16'hF0A5, 0, 1'b0, 16'hF0A5, 1'b0, 0);
        run_op("amt5", 16'h8001, 5, 1'b0, 16'h0400, 1'b1, 2);
`ifdef RSHIFT_ARITH_EN
        run_op("amt15a", 16'h8000, 15, 1'b1, 16'hFFFF, 1'b0, 6);
`else
        run_op("amt15a", 16'h8000, 15, 1'b1, 16'h0001, 1'b0, 6);
`endif
        run_op("amt15l", 16'h8000, 15, 1'b0, 16'h0001, 1'b0, 6);

        // Second start during SHIFT must be ignored.
        @(negedge clk);
        op_in = 16'h1234; op_amt = 4'd8; op_arith = 1'b0; start = 1'b1;
        @(negedge clk);
        op_in = 16'hFFFF; op_amt = 4'd1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; seen_out = '0; seen_stk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                if (pulses == 0) chk("ignore done cycle", i, 0);
                pulses++; seen_out = dut_out; seen_stk = sticky;
            end
        end
        chk("ignore pulses", pulses, 1);
        chk("ignore out", int'(seen_out), 16'h0012);
        chk("ignore sticky", int'(seen_stk), 1);
        $display("op ignore: out=%h sticky=%0d pulses=%0d", seen_out, seen_stk, pulses);

        // Reset in mid-operation abandons it.
        @(negedge clk);
        op_in = 16'hABCD; op_amt = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort out", int'(dut_out), 0);
        chk("abort sticky", int'(sticky), 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort no done", pulses, 0);
        $display("op abort: pulses after reset=%0d", pulses);
        run_op("after", 16'h00F0, 4, 1'b0, 16'h000F, 1'b0, 1);

        // Random traffic: starts at any time, occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            op_in    = 16'($urandom);
            op_amt   = 4'($urandom);
            op_arith = 1'($urandom);
            rst_n    = ($urandom_range(0, 99) != 0);
            if (start && !busy && rst_n)
                $display("rand op: in=%h amt=%0d arith=%0d", op_in, op_amt, op_arith);
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
